mc_control_unit: RTL

//  Multicycle control FSM for the 32-bit MIPS-subset datapath. Decodes the instruction register
//  and drives the 2-bit selects of the datapath's 4:1 x32 muxes (pcsource, alusrcb), plus write enables.

---
 rtl/mc_pkg.sv | 84 ++++++++
 rtl/mc_control_unit_if.sv | 44 ++++
 rtl/mc_decode.sv | 49 ++++
 rtl/mc_control_unit.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
`default_nettype none
//==============================================================================
// Module   : mc_pkg
// Desc     : Shared encodings for the multicycle MIPS-subset control unit.
// Revision : 1.0 - initial release
//==============================================================================
package mc_pkg;

    localparam logic [2:0] ST_IF  = 3'd0;
    localparam logic [2:0] ST_ID  = 3'd1;
    localparam logic [2:0] ST_EXE = 3'd2;
    localparam logic [2:0] ST_MEM = 3'd3;
    localparam logic [2:0] ST_WB  = 3'd4;

    typedef enum logic [2:0] {
        S_IF  = ST_IF,
        S_ID  = ST_ID,
        S_EXE = ST_EXE,
        S_MEM = ST_MEM,
        S_WB  = ST_WB
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] F_SLL = 6'h00;
    localparam logic [5:0] F_SRL = 6'h02;
    localparam logic [5:0] F_SRA = 6'h03;
    localparam logic [5:0] F_JR  = 6'h08;
    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_XOR = 6'h26;

    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_BRANCH = 2'b01;
    localparam logic [1:0] PCSRC_REGA   = 2'b10;
    localparam logic [1:0] PCSRC_JUMP   = 2'b11;

    localparam logic [1:0] ALUSRCB_REGB     = 2'b00;
    localparam logic [1:0] ALUSRCB_CONST4   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM      = 2'b10;
    localparam logic [1:0] ALUSRCB_IMM_SHL2 = 2'b11;

    // jump covers the absolute-target forms (j, jal); jr is separate
    typedef struct packed {
        logic       rtype;
        logic       itype;
        logic       branch;
        logic       bne;
        logic       mem;
        logic       load;
        logic       shift;
        logic       zext;
        logic       jump;
        logic       jal;
        logic       jr;
        logic       illegal;
        logic [3:0] aluc;
    } dec_t;

endpackage
`default_nettype wire

// File: rtl/mc_control_unit_if.sv
`default_nettype none
//==============================================================================
// Module   : mc_control_unit_if
// Desc     : Instruction/status inputs and datapath control outputs.
// Revision : 1.0 - initial release
//==============================================================================
interface mc_control_unit_if;

    logic [5:0] op;
    logic [5:0] func;
    logic       z;
    logic       mem_ready;
    logic       wpc;
    logic       wir;
    logic       wmem;
    logic       wreg;
    logic       iord;
    logic       regrt;
    logic       m2reg;
    logic       jal;
    logic       sext;
    logic       shift;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsource;
    logic [3:0] aluc;
    logic [2:0] state;
    logic       illegal;
    logic       mem_err;

    modport master (
        input  op, func, z, mem_ready,
        output wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift,
               alusrca, alusrcb, pcsource, aluc, state, illegal, mem_err
    );

    modport slave (
        output op, func, z, mem_ready,
        input  wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, shift,
               alusrca, alusrcb, pcsource, aluc, state, illegal, mem_err
    );

endinterface
`default_nettype wire

// File: rtl/mc_decode.sv
`default_nettype none
//==============================================================================
// Module   : mc_decode
// Desc     : Combinational op/func decode into instruction-class flags.
// Revision : 1.0 - initial release
//==============================================================================
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output dec_t       dec
);

    always_comb begin
        dec      = '0;
        dec.aluc = ALUC_ADD;
        case (op)
            OP_RTYPE: begin
                case (func)
                    F_ADD: dec.rtype = 1'b1;
                    F_SUB: begin dec.rtype = 1'b1; dec.aluc = ALUC_SUB; end
                    F_AND: begin dec.rtype = 1'b1; dec.aluc = ALUC_AND; end
                    F_OR:  begin dec.rtype = 1'b1; dec.aluc = ALUC_OR;  end
                    F_XOR: begin dec.rtype = 1'b1; dec.aluc = ALUC_XOR; end
                    F_SLL: begin dec.rtype = 1'b1; dec.shift = 1'b1; dec.aluc = ALUC_SLL; end
                    F_SRL: begin dec.rtype = 1'b1; dec.shift = 1'b1; dec.aluc = ALUC_SRL; end
                    F_SRA: begin dec.rtype = 1'b1; dec.shift = 1'b1; dec.aluc = ALUC_SRA; end
                    F_JR:  dec.jr = 1'b1;
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_ADDI: dec.itype = 1'b1;
            OP_ANDI: begin dec.itype = 1'b1; dec.zext = 1'b1; dec.aluc = ALUC_AND; end
            OP_ORI:  begin dec.itype = 1'b1; dec.zext = 1'b1; dec.aluc = ALUC_OR;  end
            OP_XORI: begin dec.itype = 1'b1; dec.zext = 1'b1; dec.aluc = ALUC_XOR; end
            OP_LUI:  begin dec.itype = 1'b1; dec.aluc = ALUC_LUI; end
            OP_LW:   begin dec.itype = 1'b1; dec.mem = 1'b1; dec.load = 1'b1; end
            OP_SW:   dec.mem = 1'b1;
            OP_BEQ:  begin dec.branch = 1'b1; dec.aluc = ALUC_SUB; end
            OP_BNE:  begin dec.branch = 1'b1; dec.bne = 1'b1; dec.aluc = ALUC_SUB; end
            OP_J:    dec.jump = 1'b1;
            OP_JAL:  begin dec.jump = 1'b1; dec.jal = 1'b1; end
            default: dec.illegal = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mc_control_unit.sv
`default_nettype none
//==============================================================================
// Module   : mc_control_unit
// Desc     : Multicycle control FSM driving the MIPS-subset datapath selects.
// Revision : 1.0 - initial release
//==============================================================================
module mc_control_unit
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    mc_control_unit_if.master   bus
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t     state_reg;
    state_t     next_state;
    logic [7:0] wait_cnt;
    logic       wait_phase;
    logic       timeout;
    dec_t       dec;

    mc_decode u_decode (
        .op   (bus.op),
        .func (bus.func),
        .dec  (dec)
    );

    assign wait_phase = ((state_reg == S_IF) || (state_reg == S_MEM)) && !bus.mem_ready;
    assign timeout    = wait_phase && (wait_cnt == TIMEOUT_LAST);
    assign bus.state  = state_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IF;
            wait_cnt  <= 8'd0;
        end else begin
            state_reg <= next_state;
            // every exit from IF/MEM (ready or timeout) restarts the count
            wait_cnt  <= (wait_phase && !timeout) ? wait_cnt + 8'd1 : 8'd0;
        end
    end

    always_comb begin
        next_state   = state_reg;
        bus.wpc      = 1'b0;
        bus.wir      = 1'b0;
        bus.wmem     = 1'b0;
        bus.wreg     = 1'b0;
        bus.iord     = 1'b0;
        bus.regrt    = 1'b0;
        bus.m2reg    = 1'b0;
        bus.jal      = 1'b0;
        bus.sext     = 1'b0;
        bus.shift    = 1'b0;
        bus.alusrca  = 1'b0;
        bus.alusrcb  = ALUSRCB_REGB;
        bus.pcsource = PCSRC_ALU;
        bus.aluc     = ALUC_ADD;
        bus.illegal  = 1'b0;
        bus.mem_err  = 1'b0;

        case (state_reg)
            S_IF: begin
                bus.alusrcb = ALUSRCB_CONST4;
                if (bus.mem_ready) begin
                    bus.wir    = 1'b1;
                    bus.wpc    = 1'b1;
                    next_state = S_ID;
                end else if (timeout) begin
                    bus.mem_err = 1'b1;
                end
            end
            S_ID: begin
                // speculative branch target computed into ALUOut
                bus.alusrcb = ALUSRCB_IMM_SHL2;
                bus.sext    = 1'b1;
                next_state  = S_IF;
                if (dec.illegal) begin
                    bus.illegal = 1'b1;
                end else if (dec.jr) begin
                    bus.pcsource = PCSRC_REGA;
                    bus.wpc      = 1'b1;
                end else if (dec.jump) begin
                    bus.pcsource = PCSRC_JUMP;
                    bus.wpc      = 1'b1;
                    bus.wreg     = dec.jal;
                    bus.jal      = dec.jal;
                end else begin
                    next_state = S_EXE;
                end
            end
            S_EXE: begin
                bus.aluc    = dec.aluc;
                bus.alusrca = 1'b1;
                if (dec.rtype) begin
                    bus.shift  = dec.shift;
                    next_state = S_WB;
                end else if (dec.branch) begin
                    next_state = S_IF;
                    if (dec.bne ? !bus.z : bus.z) begin
                        bus.pcsource = PCSRC_BRANCH;
                        bus.wpc      = 1'b1;
                    end
                end else begin
                    bus.alusrcb = ALUSRCB_IMM;
                    bus.sext    = !dec.zext;
                    next_state  = dec.mem ? S_MEM : S_WB;
                end
            end
            S_MEM: begin
                bus.iord = 1'b1;
                if (bus.mem_ready) begin
                    bus.wmem   = !dec.load;
                    next_state = dec.load ? S_WB : S_IF;
                end else if (timeout) begin
                    bus.mem_err = 1'b1;
                    next_state  = S_IF;
                end
            end
            S_WB: begin
                bus.wreg   = 1'b1;
                bus.regrt  = dec.itype;
                bus.m2reg  = dec.load;
                next_state = S_IF;
            end
            default: next_state = S_IF;
        endcase

        if (rst) begin
            bus.wpc     = 1'b0;
            bus.wir     = 1'b0;
            bus.wmem    = 1'b0;
            bus.wreg    = 1'b0;
            bus.illegal = 1'b0;
            bus.mem_err = 1'b0;
        end
    end

endmodule
`default_nettype wire
